// File: rtl/bonus_ship_scheduler.sv
// Bonus ship lifecycle sequencer: random wait, flight with watchdog, hit explosion
// and score award derived from the player's shot count.
module bonus_ship_scheduler #(
  parameter int MIN_DELAY_FRAMES  = 300,
  parameter int HIT_SHOW_FRAMES   = 30,
  parameter int MAX_FLIGHT_FRAMES = 400
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       standBy,
  input  logic       gameEnded,
  input  logic       bonusFireCollision,
  input  logic       shipOffScreen,
  input  logic       playerFire,
  input  logic [9:0] rndVal,
  output logic       rise,
  output logic       launch,
  output logic       direction,
  output logic       shipActive,
  output logic       explodeShow,
  output logic       scoreValid,
  output logic [8:0] scoreValue
);

  localparam int FlightW = $clog2(MAX_FLIGHT_FRAMES + 1);
  localparam int HitW    = $clog2(HIT_SHOW_FRAMES + 1);

  typedef enum logic [1:0] {IDLE, WAIT, FLYING, HIT} state_t;

  state_t             state;
  logic [10:0]        delayCnt;
  logic [FlightW-1:0] flightCnt;
  logic [HitW-1:0]    hitCnt;
  logic [3:0]         shotCnt;
  logic               playGame;
  logic [10:0]        delayLoad;
  logic [3:0]         shotMod;
  logic [8:0]         hitPoints;

  assign playGame  = ~(standBy | gameEnded);
  assign delayLoad = 11'(MIN_DELAY_FRAMES) + {1'b0, rndVal};
  assign shotMod   = shotCnt % 4'd3;

  // The seventh shot is the jackpot; otherwise the value cycles 50/100/150.
  always_comb begin
    hitPoints = 9'd150;
    if (shotCnt == 4'd7)
      hitPoints = 9'd300;
    else if (shotMod == 4'd0)
      hitPoints = 9'd50;
    else if (shotMod == 4'd1)
      hitPoints = 9'd100;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rise        <= 1'b0;
      launch      <= 1'b0;
      direction   <= 1'b0;
      shipActive  <= 1'b0;
      explodeShow <= 1'b0;
      scoreValid  <= 1'b0;
      scoreValue  <= '0;
      delayCnt    <= '0;
      flightCnt   <= '0;
      hitCnt      <= '0;
      shotCnt     <= '0;
    end else if (!playGame) begin
      // Game stop parks the ship; direction and the last score survive.
      state       <= IDLE;
      rise        <= 1'b0;
      launch      <= 1'b0;
      shipActive  <= 1'b0;
      explodeShow <= 1'b0;
      scoreValid  <= 1'b0;
      delayCnt    <= '0;
      flightCnt   <= '0;
      hitCnt      <= '0;
      shotCnt     <= '0;
    end else begin
      rise       <= 1'b0;
      launch     <= 1'b0;
      scoreValid <= 1'b0;
      if (state != IDLE && playerFire)
        shotCnt <= (shotCnt == 4'd14) ? 4'd0 : shotCnt + 4'd1;
      case (state)
        IDLE: begin
          state    <= WAIT;
          shotCnt  <= '0;
          delayCnt <= delayLoad;
          rise     <= 1'b1;
        end
        WAIT: begin
          if (startOfFrame) begin
            if (delayCnt == 11'd0) begin
              state      <= FLYING;
              launch     <= 1'b1;
              direction  <= ~direction;
              flightCnt  <= '0;
              shipActive <= 1'b1;
            end else begin
              delayCnt <= delayCnt - 11'd1;
            end
          end
        end
        FLYING: begin
          // A hit outranks leaving the screen and the watchdog.
          if (bonusFireCollision) begin
            state       <= HIT;
            shipActive  <= 1'b0;
            explodeShow <= 1'b1;
            scoreValid  <= 1'b1;
            scoreValue  <= hitPoints;
            hitCnt      <= '0;
          end else if (shipOffScreen || flightCnt == FlightW'(MAX_FLIGHT_FRAMES)) begin
            state      <= WAIT;
            shipActive <= 1'b0;
            delayCnt   <= delayLoad;
            rise       <= 1'b1;
          end else if (startOfFrame) begin
            flightCnt <= flightCnt + 1'b1;
          end
        end
        HIT: begin
          if (hitCnt == HitW'(HIT_SHOW_FRAMES)) begin
            state       <= WAIT;
            explodeShow <= 1'b0;
            delayCnt    <= delayLoad;
            rise        <= 1'b1;
          end else if (startOfFrame) begin
            hitCnt <= hitCnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bonus_ship_scheduler.md
# bonus_ship_scheduler

Sequences the bonus (mystery) ship across its lifecycle: waiting between appearances, flight, hit explosion, and score award. Sits between the frame timing and game-state logic and the bonus ship datapath, which comprises the mover, random generator and bitmap. It issues launch and random-advance pulses, holds the ship active or exploding, and reports the point value of a hit from the player's shot count.

## Interface
Parameters:
- MIN_DELAY_FRAMES, 300: minimum frames between the end of one appearance and the next launch.
- HIT_SHOW_FRAMES, 30: frames the explosion is displayed after a hit.
- MAX_FLIGHT_FRAMES, 400: flight watchdog; the flight is force-ended after this many frames.

Ports (clock and reset first):
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- startOfFrame  in  1  one-cycle pulse per frame.
- standBy  in  1  game in standby.
- gameEnded  in  1  game over.
- bonusFireCollision  in  1  player shot hit the bonus ship; level or pulse.
- shipOffScreen  in  1  mover reports the ship has left the visible area.
- playerFire  in  1  one-cycle pulse per player shot launched.
- rndVal  in  10  current random value, 0..1023.
- rise  out  1  one-cycle pulse requesting a new random value.
- launch  out  1  one-cycle pulse that starts the mover at its entry edge.
- direction  out  1  0 = left-to-right, 1 = right-to-left; valid while shipActive.
- shipActive  out  1  ship flying; gates the alive/draw path.
- explodeShow  out  1  explosion graphic enable.
- scoreValid  out  1  one-cycle pulse on a hit.
- scoreValue  out  9  points for the hit; held until the next hit.

## Operation
- playGame = ~(standBy | gameEnded), computed combinationally inside the block.
- The FSM has four states: IDLE, WAIT, FLYING and HIT.
- IDLE:
  - All outputs are 0.
  - When playGame = 1, go to WAIT.
  - On that transition, clear shotCnt to 0.
- Entry to WAIT (from any state):
  - Load delayCnt (11 bits) = MIN_DELAY_FRAMES + rndVal.
  - Pulse rise in the same cycle.
- WAIT:
  - Decrement delayCnt on each startOfFrame.
  - When delayCnt is 0 on a startOfFrame, go to FLYING and pulse launch.
- Entry to FLYING:
  - Toggle direction.
  - Clear flightCnt.
  - Set shipActive = 1.
- FLYING:
  - flightCnt increments on startOfFrame.
  - If bonusFireCollision, go to HIT.
  - Else if shipOffScreen, or flightCnt reaches MAX_FLIGHT_FRAMES, go to WAIT with no score.
- Entry to HIT:
  - Set shipActive = 0 and explodeShow = 1.
  - Pulse scoreValid.
  - Latch scoreValue from shotCnt, where m = shotCnt mod 3:
    - shotCnt == 7 gives 300.
    - Otherwise m = 0 gives 50, m = 1 gives 100, m = 2 gives 150.
  - Clear hitCnt.
- HIT:
  - hitCnt increments on startOfFrame.
  - At HIT_SHOW_FRAMES, clear explodeShow and go to WAIT.
- shotCnt:
  - 4 bits; increments on playerFire in any non-IDLE state.
  - Wraps 14 -> 0, so it counts modulo 15.
- Game stop: whenever playGame = 0 in any non-IDLE state, go to IDLE next cycle.
  - Clear shipActive, explodeShow and all counters.
  - direction keeps its value.

## Timing
- Reset: state IDLE; rise, launch, direction, shipActive, explodeShow and scoreValid are 0; scoreValue and all counters are 0.
- State transitions take effect at the clock edge after the triggering condition.
- Registered outputs change together with the state:
  - launch and rise are asserted in the first cycle of the new state.
  - shipActive and explodeShow follow the state with no extra delay.
- Frame-level timing:
  - The delay from WAIT entry to launch is MIN_DELAY_FRAMES + rndVal + 1 startOfFrame pulses.
  - The explosion lasts exactly HIT_SHOW_FRAMES startOfFrame pulses.
- Simultaneous events:
  - bonusFireCollision and shipOffScreen in the same cycle: hit wins.
  - bonusFireCollision and the watchdog expiry in the same cycle: hit wins.
- bonusFireCollision is ignored outside FLYING. A level held across a HIT entry produces exactly one scoreValid.
- playerFire in the same cycle as a HIT entry: the score uses the pre-increment shotCnt.
- playGame = 0 has priority over all other conditions in every state.
- reset has priority over everything, including playGame.
- startOfFrame is ignored in IDLE.

## Test plan
- Reset with MIN_DELAY_FRAMES = 4, then playGame = 1 with rndVal = 3:
  - rise is pulsed once on WAIT entry.
  - launch is pulsed after the 8th startOfFrame.
  - direction becomes 1 and shipActive = 1.
- In FLYING with shotCnt = 7, assert bonusFireCollision and shipOffScreen in the same cycle:
  - One scoreValid pulse with scoreValue = 300.
  - explodeShow = 1 for HIT_SHOW_FRAMES frames, then return to WAIT with a new rise pulse.
- 16 playerFire pulses, then a hit:
  - shotCnt = 1, so scoreValue = 100.
  - Check the wrap 14 -> 0 along the way.
- Hold shipOffScreen = 0 and no collision:
  - The watchdog ends the flight after MAX_FLIGHT_FRAMES frames.
  - No scoreValid is issued; WAIT is re-entered.
- Assert gameEnded mid-FLYING:
  - The next cycle is IDLE with shipActive = 0.
  - A later bonusFireCollision produces no scoreValid.
  - Restarting the game clears shotCnt.
- Assert reset during HIT:
  - All outputs are 0 on the next cycle.
  - direction returns to 0.
